// File: rtl/uncached_axi_bridge.sv
// Uncached SRAM-like to AXI3 bridge: one single-beat read or write
// outstanding at a time, so uncached accesses complete in program order.
module uncached_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd1,
    parameter int         ADDR_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_addr_ok,
    output logic              mem_data_ok,
    output logic [31:0]       mem_rdata,
    output logic              mem_err,
    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [3:0]        rid,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [3:0]        awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [3:0]        wid,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [3:0]        bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR      = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [3:0]        strb_q;
    logic              aw_done;
    logic              w_done;
    logic              data_ok_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [3:0]        strb_d;
    logic [1:0]        size_d;
    logic              unused_ok;

    // Single ID, single beat: response ID and last flag carry no information.
    assign unused_ok = ^{rid, bid, rlast};

    always_comb begin
        unique case (mem_size)
            2'd0:    strb_d = 4'b0001 << mem_addr[1:0];
            2'd1:    strb_d = 4'b0011 << mem_addr[1:0];
            default: strb_d = 4'b1111;
        endcase
    end

    assign size_d = (mem_size == 2'd3) ? 2'd2 : mem_size;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        addr_q  <= mem_addr;
                        size_q  <= size_d;
                        wdata_q <= mem_wdata;
                        strb_q  <= strb_d;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= mem_wr ? WR : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (arready) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (rvalid) begin
                        rdata_q   <= rdata;
                        err_q     <= |rresp;
                        data_ok_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                WR: begin
                    if (awready) aw_done <= 1'b1;
                    if (wready)  w_done  <= 1'b1;
                    if ((aw_done | awready) && (w_done | wready))
                        state <= WR_RESP;
                end
                WR_RESP: begin
                    if (bvalid) begin
                        err_q     <= |bresp;
                        data_ok_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr_ok = (state == IDLE);
    assign mem_data_ok = data_ok_q;
    assign mem_err     = err_q;
    assign mem_rdata   = rdata_q;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 4'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = (state == RD_ADDR);
    assign rready  = (state == RD_DATA);

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 4'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = (state == WR) && !aw_done;

    assign wid    = AXI_ID;
    assign wdata  = wdata_q;
    assign wstrb  = strb_q;
    assign wlast  = 1'b1;
    assign wvalid = (state == WR) && !w_done;
    assign bready = (state == WR_RESP);

endmodule

// File: doc/uncached_axi_bridge.md
Name: uncached_axi_bridge

Overview:
- Downstream of the memory stage's uncached SRAM-like port (mem_req/mem_wr/mem_size/mem_addr/mem_wdata, returns mem_addr_ok/mem_data_ok/mem_rdata).
- Converts each accepted request into exactly one single-beat AXI3 read or write transaction on the data-side uncached AXI master.
- Only one transaction is outstanding at a time, so uncached loads and stores complete strictly in program order.

Parameters:
- AXI_ID, 4'd1, constant value driven on arid/awid/wid.
- ADDR_W, 32, address width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- mem_req  in  1  request valid
- mem_wr  in  1  1 = write, 0 = read
- mem_size  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word)
- mem_addr  in  ADDR_W  physical byte address
- mem_wdata  in  32  write data, already lane-aligned by the requester
- mem_addr_ok  out  1  request accepted this cycle
- mem_data_ok  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while mem_data_ok is high and held afterwards
- mem_err  out  1  pulses with mem_data_ok when rresp/bresp != 0
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/4/3/2/2/4/3/1;  arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1;  rready  out  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid  out  4/32/4/3/2/2/4/3/1;  awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1;  wready  in  1
- bid/bresp/bvalid  in  4/2/1;  bready  out  1

Behaviour:
- Reset (aresetn = 0, async):
  - state = IDLE; all valid/ready outputs = 0.
  - mem_data_ok = 0, mem_err = 0, mem_rdata = 0, and all latched address/data/strb = 0.
  - Reset mid-transaction abandons it with no completion pulse.
- States: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP.
- mem_addr_ok = (state == IDLE), combinational.
  - A request is accepted on mem_req && mem_addr_ok.
  - On accept, latch wr, addr, size and wdata, and compute strb from size and addr[1:0]:
    - byte: 4'b0001 << a
    - half: 4'b0011 << a
    - word: 4'b1111
  - mem_req while not in IDLE is ignored; the requester must hold it.
- Read path:
  - Accept -> RD_ADDR. arvalid = 1 from the next cycle, araddr = latched addr, arsize = {1'b0, size}.
  - ar handshake -> RD_DATA. rready = 1 only in RD_DATA.
  - r handshake -> next cycle: mem_data_ok = 1, mem_rdata = rdata, mem_err = |rresp; state = IDLE.
- Write path:
  - Accept -> WR. awvalid and wvalid are both raised the next cycle.
  - Each valid drops independently after its own handshake (aw_done / w_done flags); handshakes may occur in either order or in the same cycle.
  - Both done -> WR_RESP, bready = 1.
  - b handshake -> next cycle: mem_data_ok = 1, mem_err = |bresp; state = IDLE.
- Constant fields:
  - arlen = awlen = 0, arburst = awburst = 2'b01, lock = 0, cache = 0, prot = 0.
  - wlast = 1 whenever wvalid = 1. ids = AXI_ID.
- Valid/data stability: araddr, awaddr, wdata and wstrb are registered and stable while the corresponding valid is high. A valid is never deasserted before its handshake.
- mem_data_ok and mem_err are exactly one cycle wide. mem_rdata keeps the last read value; writes do not change it.
- Completion cycle: state is already IDLE, so mem_addr_ok = 1 and a new request can be accepted in the same cycle as mem_data_ok.
- Minimum latency, slave always ready:
  - read: accept c0, ar c1, r c2, data_ok c3
  - write: accept c0, aw+w c1, b c2, data_ok c3
- rid/bid/rlast are not checked (single ID, single beat).

Test Plan:
- Word read 0x1FAF_F020, slave always ready, rdata 0xDEAD_BEEF -> araddr 0x1FAFF020, arsize 2, arlen 0; mem_data_ok pulses at c3 with mem_rdata 0xDEADBEEF; mem_err 0.
- Byte write addr 0x1FAF_0003, wdata 0xAB00_0000 -> awsize 0, wstrb 4'b1000, wlast 1; one mem_data_ok pulse after the b handshake. Half write at offset 2 -> wstrb 4'b1100.
- awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle; awvalid/awaddr held stable 5 cycles; bready rises only after the aw handshake.
- Second mem_req held during an outstanding read -> mem_addr_ok 0 until the completion cycle; the second request is accepted in the mem_data_ok cycle and issued exactly once.
- rresp = 2'b10 on a read, then bresp = 2'b11 on a write -> mem_err pulses with each mem_data_ok; state returns to IDLE.
- aresetn asserted while in RD_DATA -> arvalid/rready/mem_data_ok drop to 0 immediately (async); after release, mem_addr_ok = 1 and no stale completion pulse appears.
